scmp_alu_seq: RTL

Parametrised, registered successor to the single-cycle SC/MP ALU. It is generalised to W-bit operands and adds decimal add, plus multi-cycle unsigned multiply and divide. Operations run under a start/busy/done handshake, and all results and flags are held in output registers. It sits between the microcode sequencer and the accumulator/extension registers of the wider-datapath core.

---
 rtl/scmp_alu_seq.sv | 299 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/scmp_alu_seq.sv
// scmp_alu_seq: registered, W-bit SC/MP-style ALU with decimal add and
// multi-cycle unsigned multiply / divide under a start/busy/done handshake.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start, op[3:0]    request and operation code, sampled while busy=0
//   A, B              operands (B is multiplier / divisor for MPY / DIV)
//   Cy_i, Ov_i        incoming carry / overflow flags
//   busy              high while a MPY / DIV iterates
//   done              one-cycle pulse, results and flags valid
//   res, res_hi       primary result; MPY high half / DIV remainder
//   Cy_o, HCy_o, Ov_o carry out, carry out of bit 3, overflow out
//   Cy_sgn_o          B sign bit captured for ADD / ADDNC
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start
// RUN   | MPY shift-add or DIV restore-subtract, one step per cycle
// DONE  | results loaded, done asserted; a new start is accepted here

module scmp_alu_seq #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [3:0]   op,
   input  logic [W-1:0] A,
   input  logic [W-1:0] B,
   input  logic         Cy_i,
   input  logic         Ov_i,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] res,
   output logic [W-1:0] res_hi,
   output logic         Cy_o,
   output logic         HCy_o,
   output logic         Ov_o,
   output logic         Cy_sgn_o
);

   localparam int CNT_W = $clog2(W + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

   localparam logic [3:0] OP_AND   = 4'd0;
   localparam logic [3:0] OP_OR    = 4'd1;
   localparam logic [3:0] OP_XOR   = 4'd2;
   localparam logic [3:0] OP_ADD   = 4'd3;
   localparam logic [3:0] OP_ADDNC = 4'd4;
   localparam logic [3:0] OP_RRL   = 4'd5;
   localparam logic [3:0] OP_INC   = 4'd6;
   localparam logic [3:0] OP_DEC   = 4'd7;
   localparam logic [3:0] OP_NUL   = 4'd8;
   localparam logic [3:0] OP_DAD   = 4'd9;
   localparam logic [3:0] OP_MPY   = 4'd10;
   localparam logic [3:0] OP_DIV   = 4'd11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [W-1:0]     hi_q, hi_d;
   logic [W-1:0]     lo_q, lo_d;
   logic [W-1:0]     b_q, b_d;
   logic             div_q, div_d;
   logic             cy_lat_q, cy_lat_d;
   logic             ov_lat_q, ov_lat_d;

   logic [W-1:0]     res_q, res_d;
   logic [W-1:0]     res_hi_q, res_hi_d;
   logic             cy_q, cy_d;
   logic             hcy_q, hcy_d;
   logic             ov_q, ov_d;
   logic             sgn_q, sgn_d;

   // single-cycle datapath
   logic             add_cin;
   logic [W:0]       add_sum;
   logic [W:0]       inc_sum;
   logic [W:0]       dec_dif;
   logic [W-1:0]     dad_res;
   logic [4:0]       dad_nib;
   logic             dad_c;
   logic             dad_hcy;
   logic [W-1:0]     s_res;
   logic [W-1:0]     s_hi;
   logic             s_cy, s_hcy, s_ov, s_sgn;

   // iterative datapath
   logic [W:0]       mpy_sum;
   logic [W-1:0]     mpy_hi_nx, mpy_lo_nx;
   logic [W:0]       div_sh;
   logic [W-1:0]     div_df;
   logic             div_ok;
   logic [W-1:0]     div_rem_nx, div_quo_nx;

   assign add_cin = (op == OP_ADD) && Cy_i;
   assign add_sum = {1'b0, A} + {1'b0, B} + {{W{1'b0}}, add_cin};
   assign inc_sum = {1'b0, A} + {{W{1'b0}}, 1'b1};
   assign dec_dif = {1'b0, A} - {{W{1'b0}}, 1'b1};

   always_comb begin
      dad_c   = Cy_i;
      dad_res = '0;
      dad_hcy = 1'b0;
      dad_nib = '0;
      for (int i = 0; i < W / 4; i++) begin
         dad_nib = {1'b0, A[4*i +: 4]} + {1'b0, B[4*i +: 4]} + {4'b0, dad_c};
         if (dad_nib > 5'd9) begin
            dad_nib = dad_nib + 5'd6;
            dad_c   = 1'b1;
         end else begin
            dad_c   = 1'b0;
         end
         dad_res[4*i +: 4] = dad_nib[3:0];
         if (i == 0) begin
            dad_hcy = dad_c;
         end
      end
   end

   always_comb begin
      s_res = A;
      s_hi  = '0;
      s_cy  = Cy_i;
      s_hcy = 1'b0;
      s_ov  = Ov_i;
      s_sgn = 1'b0;
      case (op)
         OP_AND: s_res = A & B;
         OP_OR:  s_res = A | B;
         OP_XOR: s_res = A ^ B;
         OP_ADD, OP_ADDNC: begin
            s_res = add_sum[W-1:0];
            s_cy  = add_sum[W];
            // carry into bit 4 is the carry out of bit 3
            s_hcy = A[4] ^ B[4] ^ add_sum[4];
            s_ov  = (A[W-1] == B[W-1]) && (add_sum[W-1] != A[W-1]);
            s_sgn = B[W-1];
         end
         OP_RRL: begin
            s_res = {Cy_i, A[W-1:1]};
            s_cy  = A[0];
         end
         OP_INC: begin
            s_res = inc_sum[W-1:0];
            s_cy  = inc_sum[W];
         end
         OP_DEC: begin
            s_res = dec_dif[W-1:0];
            s_cy  = dec_dif[W];
         end
         OP_NUL: s_res = B;
         OP_DAD: begin
            s_res = dad_res;
            s_cy  = dad_c;
            s_hcy = dad_hcy;
         end
         // only reached with B == 0: divide-by-zero short path
         OP_DIV: begin
            s_res = '1;
            s_hi  = A;
            s_ov  = 1'b1;
         end
         default: ;
      endcase
   end

   // multiply: {hi,lo} shifts right, multiplicand added into hi when lo[0]
   assign mpy_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(W+1){1'b0}});
   assign mpy_hi_nx = mpy_sum[W:1];
   assign mpy_lo_nx = {mpy_sum[0], lo_q[W-1:1]};

   // divide: hi holds the partial remainder, lo shifts dividend out and quotient in
   assign div_sh     = {hi_q, lo_q[W-1]};
   assign div_ok     = div_sh >= {1'b0, b_q};
   assign div_df     = div_sh[W-1:0] - b_q;
   assign div_rem_nx = div_ok ? div_df : div_sh[W-1:0];
   assign div_quo_nx = {lo_q[W-2:0], div_ok};

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      b_d      = b_q;
      div_d    = div_q;
      cy_lat_d = cy_lat_q;
      ov_lat_d = ov_lat_q;
      res_d    = res_q;
      res_hi_d = res_hi_q;
      cy_d     = cy_q;
      hcy_d    = hcy_q;
      ov_d     = ov_q;
      sgn_d    = sgn_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               if ((op == OP_MPY) || ((op == OP_DIV) && (B != '0))) begin
                  state_d  = ST_RUN;
                  cnt_d    = '0;
                  hi_d     = '0;
                  lo_d     = A;
                  b_d      = B;
                  div_d    = (op == OP_DIV);
                  cy_lat_d = Cy_i;
                  ov_lat_d = Ov_i;
               end else begin
                  state_d  = ST_DONE;
                  res_d    = s_res;
                  res_hi_d = s_hi;
                  cy_d     = s_cy;
                  hcy_d    = s_hcy;
                  ov_d     = s_ov;
                  sgn_d    = s_sgn;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (div_q) begin
               hi_d = div_rem_nx;
               lo_d = div_quo_nx;
            end else begin
               hi_d = mpy_hi_nx;
               lo_d = mpy_lo_nx;
            end
            if (cnt_q == CNT_LAST) begin
               state_d = ST_DONE;
               cnt_d   = '0;
               hcy_d   = 1'b0;
               sgn_d   = 1'b0;
               if (div_q) begin
                  res_d    = div_quo_nx;
                  res_hi_d = div_rem_nx;
                  cy_d     = cy_lat_q;
                  ov_d     = 1'b0;
               end else begin
                  res_d    = mpy_lo_nx;
                  res_hi_d = mpy_hi_nx;
                  cy_d     = |mpy_hi_nx;
                  ov_d     = ov_lat_q;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         b_q      <= '0;
         div_q    <= 1'b0;
         cy_lat_q <= 1'b0;
         ov_lat_q <= 1'b0;
         res_q    <= '0;
         res_hi_q <= '0;
         cy_q     <= 1'b0;
         hcy_q    <= 1'b0;
         ov_q     <= 1'b0;
         sgn_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         b_q      <= b_d;
         div_q    <= div_d;
         cy_lat_q <= cy_lat_d;
         ov_lat_q <= ov_lat_d;
         res_q    <= res_d;
         res_hi_q <= res_hi_d;
         cy_q     <= cy_d;
         hcy_q    <= hcy_d;
         ov_q     <= ov_d;
         sgn_q    <= sgn_d;
      end
   end

   assign busy     = (state_q == ST_RUN);
   assign done     = (state_q == ST_DONE);
   assign res      = res_q;
   assign res_hi   = res_hi_q;
   assign Cy_o     = cy_q;
   assign HCy_o    = hcy_q;
   assign Ov_o     = ov_q;
   assign Cy_sgn_o = sgn_q;

endmodule
